muldiv_hilo_unit: RTL and testbench

Multi-cycle multiply/divide unit that owns the architectural HI/LO register pair for the MIPS execute stage. It takes the HI/LO-class operations out of the single-cycle ALU path: MULT/MULTU, MADD/MADDU, MSUB/MSUBU, DIV/DIVU, MTHI and MTLO. It executes them iteratively over WIDTH cycles and reports `Busy`, so hazard logic can stall MFHI/MFLO and any further HI/LO op. The operand width is parametrised, and an in-flight operation can be aborted by a pipeline flush.

---
 rtl/muldiv_hilo_unit.sv | 214 +++++++++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit
//   Iterative multiply/divide unit owning the architectural HI/LO pair.
//   MULT/MULTU/MADD/MADDU/MSUB/MSUBU use radix-2 shift-add over WIDTH cycles.
//   DIV/DIVU use restoring division over WIDTH cycles.
//   MTHI/MTLO write in a single cycle.
//   Optional feature macro: MULDIV_DIV_EN. When it is undefined, the divider
//   is absent and ops 6/7 are treated as no-ops.
// Ports:
//   Clk, Reset_n - rising-edge clock, asynchronous active-low reset
//   Start, Op    - request strobe (sampled in IDLE only) and opcode
//   A, B         - rs / rt operands
//   Flush        - abort any in-flight or requested operation
//   Busy         - iterative operation in progress
//   Done         - one-cycle pulse when HI/LO has been written
//   Hi, Lo       - architectural HI / LO
module muldiv_hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL
`ifdef MULDIV_DIV_EN
    , S_DIV
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;   // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opb_q, opb_d;   // multiplicand or divisor magnitude
  logic               neg_q, neg_d;   // negate product / quotient at writeback
  logic               madd_q, madd_d;
  logic               msub_q, msub_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
`ifdef MULDIV_DIV_EN
  logic               rneg_q, rneg_d; // remainder takes the dividend's sign
`endif

  logic               op_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, mul_prod, mul_res, hilo;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     div_trial, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   div_quo, div_rem;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      madd_q  <= 1'b0;
      msub_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      madd_q  <= madd_d;
      msub_q  <= msub_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MULDIV_DIV_EN
      rneg_q  <= rneg_d;
`endif
    end
  end

  // Datapath: one shift-add / restoring step per cycle, plus final sign fixup.
  always_comb begin
    op_signed = ~Op[0];
    a_mag     = (op_signed && A[WIDTH-1]) ? -A : A;
    b_mag     = (op_signed && B[WIDTH-1]) ? -B : B;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    mul_prod  = neg_q ? -mul_next : mul_next;
    hilo      = {hi_q, lo_q};
    if (madd_q)      mul_res = hilo + mul_prod;
    else if (msub_q) mul_res = hilo - mul_prod;
    else             mul_res = mul_prod;

`ifdef MULDIV_DIV_EN
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opb_q};
    div_next  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    div_quo   = neg_q  ? -div_next[WIDTH-1:0]       : div_next[WIDTH-1:0];
    div_rem   = rneg_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    madd_d  = madd_q;
    msub_d  = msub_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
    rneg_d  = rneg_q;
`endif

    if (Flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            case (Op)
              4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
                state_d = S_MUL;
                cnt_d   = CW'(WIDTH - 1);
                acc_d   = {{WIDTH{1'b0}}, b_mag};
                opb_d   = a_mag;
                neg_d   = op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                madd_d  = (Op == 4'd2) || (Op == 4'd3);
                msub_d  = (Op == 4'd4) || (Op == 4'd5);
              end
`ifdef MULDIV_DIV_EN
              4'd6, 4'd7: begin
                state_d = S_DIV;
                cnt_d   = CW'(WIDTH - 1);
                acc_d   = {{WIDTH{1'b0}}, a_mag};
                opb_d   = b_mag;
                // A zero divisor keeps the quotient positive (all ones) and
                // the remainder sign-restores back to A.
                neg_d   = op_signed & (A[WIDTH-1] ^ B[WIDTH-1]) & (|B);
                rneg_d  = op_signed & A[WIDTH-1];
                madd_d  = 1'b0;
                msub_d  = 1'b0;
              end
`endif
              4'd8: begin
                hi_d   = A;
                done_d = 1'b1;
              end
              4'd9: begin
                lo_d   = A;
                done_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc_d = mul_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            {hi_d, lo_d} = mul_res;
            done_d       = 1'b1;
          end
        end
`ifdef MULDIV_DIV_EN
        S_DIV: begin
          acc_d = div_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = div_rem;
            lo_d    = div_quo;
            done_d  = 1'b1;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign Busy = (state_q != S_IDLE);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Testbench for muldiv_hilo_unit: directed literal cases plus randomized
// traffic checked each cycle against a transaction-level arithmetic model.
module tb_muldiv_hilo_unit;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [3:0]    op_i;
  logic [W-1:0]  a_i;
  logic [W-1:0]  b_i;
  logic          flush;
  logic          busy_o;
  logic          done_o;
  logic [W-1:0]  hi_o;
  logic [W-1:0]  lo_o;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .Clk    (clk),
    .Reset_n(rst_n),
    .Start  (start),
    .Op     (op_i),
    .A      (a_i),
    .B      (b_i),
    .Flush  (flush),
    .Busy   (busy_o),
    .Done   (done_o),
    .Hi     (hi_o),
    .Lo     (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] hilo);
    logic [63:0] p;
    longint      sq, sr;
    if (op == 4'd6 || op == 4'd7) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (op == 4'd6) begin
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        return {sr[31:0], sq[31:0]};
      end
      return {a % b, a / b};
    end
    if (op[0] == 1'b0) p = 64'(longint'($signed(a)) * longint'($signed(b)));
    else               p = {32'd0, a} * {32'd0, b};
    if (op == 4'd2 || op == 4'd3) return hilo + p;
    if (op == 4'd4 || op == 4'd5) return hilo - p;
    return p;
  endfunction

  function automatic bit is_iter(input logic [3:0] op);
    return (op <= 4'd5) || (DIV_EN && (op == 4'd6 || op == 4'd7));
  endfunction

  int          m_cnt;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b, m_hi, m_lo;
  logic        m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (flush) begin
        m_cnt <= 0;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          {m_hi, m_lo} <= model_result(m_op, m_a, m_b, {m_hi, m_lo});
          m_done       <= 1'b1;
        end
      end else if (start) begin
        if (is_iter(op_i)) begin
          m_op  <= op_i;
          m_a   <= a_i;
          m_b   <= b_i;
          m_cnt <= W;
        end else if (op_i == 4'd8) begin
          m_hi   <= a_i;
          m_done <= 1'b1;
        end else if (op_i == 4'd9) begin
          m_lo   <= a_i;
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy_o), 64'(m_cnt != 0));
      chk("done", 64'(done_o), 64'(m_done));
      chk("hi",   64'(hi_o),   64'(m_hi));
      chk("lo",   64'(lo_o),   64'(m_lo));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int ebusy, input int stray_at);
    int busy_n;
    bit seen;
    @(negedge clk);
    start = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk);
    start  = 1'b0;
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (busy_o) busy_n++;
      if (stray_at != 0 && busy_n == stray_at) begin
        start = 1'b1; op_i = 4'd9; a_i = 32'h5555_5555;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({name, "_done"},  64'(seen),   64'(1));
    chk({name, "_cycles"}, 64'(busy_n), 64'(ebusy));
    chk({name, "_hi"},    64'(hi_o),   64'(ehi));
    chk({name, "_lo"},    64'(lo_o),   64'(elo));
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit seen_done, seen_busy;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_hi",   64'(hi_o),   64'(0));
    chk("rst_lo",   64'(lo_o),   64'(0));
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_op("mult_neg",  4'd0, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, W, 0);
    run_op("multu_max", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, W, 0);
    run_op("mult_m1",   4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, W, 0);
    run_op("mthi",      4'd8, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'h0000_0001, 0, 0);
    run_op("mtlo",      4'd9, 32'hFFFF_FFFF, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, 0, 0);
    run_op("madd",      4'd2, 32'd2,         32'd3,        32'h1234_5679, 32'h0000_0005, W, 0);
    run_op("msub",      4'd4, 32'd2,         32'd3,        32'h1234_5678, 32'hFFFF_FFFF, W, 0);

`ifdef MULDIV_DIV_EN
    run_op("div_neg",   4'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, W, 0);
    run_op("divu_z",    4'd7, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, W, 0);
    run_op("div_ovf",   4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, W, 0);
`else
    @(negedge clk);
    start = 1'b1; op_i = 4'd6; a_i = 32'hFFFF_FFF9; b_i = 32'd2;
    @(negedge clk);
    start = 1'b0;
    seen_done = 1'b0; seen_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done_o) seen_done = 1'b1;
      if (busy_o) seen_busy = 1'b1;
      @(negedge clk);
    end
    chk("divoff_done", 64'(seen_done), 64'(0));
    chk("divoff_busy", 64'(seen_busy), 64'(0));
    chk("divoff_hi",   64'(hi_o),      64'(32'h1234_5678));
    chk("divoff_lo",   64'(lo_o),      64'(32'hFFFF_FFFF));
`endif

    run_op("mthi2", 4'd8, 32'hA5A5_A5A5, 32'd0, 32'hA5A5_A5A5, lo_o, 0, 0);
    run_op("mtlo2", 4'd9, 32'h3C3C_3C3C, 32'd0, 32'hA5A5_A5A5, 32'h3C3C_3C3C, 0, 0);

    // Flush in busy cycle 10.
    @(negedge clk);
    start = 1'b1; op_i = 4'd0; a_i = 32'hFFFF_FFFD; b_i = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy_o), 64'(0));
    chk("flush_hi",   64'(hi_o),   64'(32'hA5A5_A5A5));
    chk("flush_lo",   64'(lo_o),   64'(32'h3C3C_3C3C));
    seen_done = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      if (done_o) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("flush_nodone", 64'(seen_done), 64'(0));

    // Start+Flush with MTLO in IDLE.
    start = 1'b1; op_i = 4'd9; a_i = 32'hCAFE_F00D; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("sflush_lo",   64'(lo_o),   64'(32'h3C3C_3C3C));
    chk("sflush_done", 64'(done_o), 64'(0));

    // Stray Start while busy is ignored; result completes on schedule.
    run_op("stray", 4'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, W, 3);

    // Reset pulse in busy cycle 5.
    @(negedge clk);
    start = 1'b1; op_i = 4'd1; a_i = 32'd5; b_i = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_hi",   64'(hi_o),   64'(0));
    chk("rstmid_lo",   64'(lo_o),   64'(0));
    chk("rstmid_busy", 64'(busy_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic, including Start while busy and occasional Flush.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op_i  = 4'($urandom_range(0, 15));
      a_i   = rnd_opnd();
      b_i   = rnd_opnd();
      flush = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    repeat (W + 4) @(negedge clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
